// File: rtl/movegen_scan.sv
// movegen_scan: walks the 64 squares in ascending order. For each square holding
// a piece of the side to play it strobes emit_move for that square, lets the
// external attack logic settle, captures the target flags and hands the moves
// out one at a time through a valid/ready port.
//
// Move port handshake: a move transfers on every rising edge where move_valid
// and move_ready are both high. move_valid is a function of registered state
// only (never of move_ready). Once raised, move_valid, move_from and move_to
// hold until the transfer edge or until the scan is aborted or reset.
module movegen_scan #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic         wtp,
    input  logic [255:0] i_board,
    output logic [63:0]  emit_move,
    input  logic [63:0]  target_square,
    output logic         move_valid,
    input  logic         move_ready,
    output logic [5:0]   move_from,
    output logic [5:0]   move_to,
    output logic         busy,
    output logic         done,
    output logic [7:0]   move_count
);

    // EMIT holds for SETTLE_CYCLES cycles; the counter runs 0..SETTLE_LAST.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SCAN    = 3'd1,
        EMIT    = 3'd2,
        CAPTURE = 3'd3,
        DRAIN   = 3'd4,
        FIN     = 3'd5
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [63:0] play_mask;
    logic [63:0] play_mask_now;
    logic [63:0] pend;
    logic [5:0]  src;
    logic [3:0]  settle_cnt;
    logic [5:0]  low_idx;
    logic        pend_any;
    logic        last_sq;
    logic        abort_scan;
    logic        start_ok;
    logic        handshake;

    assign pend_any   = |pend;
    assign last_sq    = (src == 6'd63);
    assign abort_scan = abort && (state != IDLE);
    assign start_ok   = start && !abort && (state == IDLE);
    assign move_from  = src;
    assign move_to    = low_idx;

    // Squares holding a non-empty piece of the side to play.
    always_comb begin
        play_mask_now = '0;
        for (int i = 0; i < 64; i++) begin
            play_mask_now[i] = (i_board[4*i +: 3] != 3'd0) && (i_board[4*i+3] == wtp);
        end
    end

    // Lowest pending target; zero when nothing is pending.
    always_comb begin
        low_idx = '0;
        for (int i = 63; i >= 0; i--) begin
            if (pend[i]) low_idx = 6'(i);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic and state-decoded outputs; abort overrides everything.
    always_comb begin
        state_next = state;
        move_valid = 1'b0;
        done       = 1'b0;
        handshake  = 1'b0;
        case (state)
            IDLE:    if (start_ok) state_next = SCAN;
            SCAN: begin
                if (play_mask[src]) state_next = EMIT;
                else if (last_sq)   state_next = FIN;
            end
            EMIT:    if (settle_cnt == SETTLE_LAST) state_next = CAPTURE;
            CAPTURE: state_next = DRAIN;
            DRAIN: begin
                move_valid = pend_any;
                handshake  = pend_any && move_ready && !abort;
                if (!pend_any) state_next = last_sq ? FIN : SCAN;
            end
            FIN: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (abort_scan) state_next = IDLE;
    end

    // Scan datapath: source pointer, strobe, pending targets, counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            play_mask  <= '0;
            pend       <= '0;
            src        <= '0;
            settle_cnt <= '0;
            emit_move  <= '0;
            busy       <= 1'b0;
            move_count <= '0;
        end else if (abort_scan) begin
            pend       <= '0;
            settle_cnt <= '0;
            emit_move  <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        play_mask  <= play_mask_now;
                        src        <= '0;
                        move_count <= '0;
                        busy       <= 1'b1;
                    end
                end
                SCAN: begin
                    if (play_mask[src]) begin
                        settle_cnt <= '0;
                        emit_move  <= 64'd1 << src;
                    end else if (!last_sq) begin
                        src <= src + 6'd1;
                    end
                end
                EMIT: settle_cnt <= settle_cnt + 4'd1;
                CAPTURE: begin
                    pend      <= target_square;
                    emit_move <= '0;
                end
                DRAIN: begin
                    if (handshake) begin
                        pend <= pend & ~(64'd1 << low_idx);
                        if (move_count != 8'hFF) move_count <= move_count + 8'd1;
                    end else if (!pend_any && !last_sq) begin
                        src <= src + 6'd1;
                    end
                end
                FIN: busy <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_movegen_scan.sv
// Bench for movegen_scan: a table of whole-scan vectors with a move scoreboard,
// followed by hand-written abort, reset and start/abort corner sequences.
module tb_movegen_scan;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         abort;
    logic         wtp;
    logic [255:0] i_board;
    logic [63:0]  emit_move;
    logic [63:0]  target_square;
    logic         move_valid;
    logic         move_ready;
    logic [5:0]   move_from;
    logic [5:0]   move_to;
    logic         busy;
    logic         done;
    logic [7:0]   move_count;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [11:0] exp_q[$];

    typedef struct {
        logic [255:0] board;
        logic         wtp;
        logic [63:0]  targets;
        int           mode;          // 0: ready high, 1: ready 0,0,1 per move, 2: random
        int           restart_at;    // cycle to pulse a second (ignored) start, -1 none
        int           exp_count;
        logic [63:0]  exp_emit_or;
        int           exp_emit_cycles;
        int           exp_done_cyc;  // -1 when latency is not fixed
    } vec_t;

    vec_t vecs[9];

    movegen_scan #(.SETTLE_CYCLES(2)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .abort(abort),
        .wtp(wtp),
        .i_board(i_board),
        .emit_move(emit_move),
        .target_square(target_square),
        .move_valid(move_valid),
        .move_ready(move_ready),
        .move_from(move_from),
        .move_to(move_to),
        .busy(busy),
        .done(done),
        .move_count(move_count)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net against a hung run.
    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] put(input logic [255:0] b, input int idx, input logic [3:0] nib);
        logic [255:0] r;
        r = b;
        r[4*idx +: 4] = nib;
        return r;
    endfunction

    // Reference: every playable square ascending, each flagged target ascending.
    task automatic push_expected(input vec_t v);
        logic [3:0] nib;
        for (int s = 0; s < 64; s++) begin
            nib = v.board[4*s +: 4];
            if (nib[2:0] != 3'd0 && nib[3] == v.wtp) begin
                for (int t = 0; t < 64; t++) begin
                    if (v.targets[t]) exp_q.push_back({6'(s), 6'(t)});
                end
            end
        end
    endtask

    task automatic pop_compare(input string name);
        logic [11:0] e;
        if (exp_q.size() == 0) begin
            check({name, "_extra_move"}, {move_from, move_to}, 64'hFFFF_FFFF);
        end else begin
            e = exp_q.pop_front();
            check(name, {move_from, move_to}, e);
        end
    endtask

    // Driver: one full scan from start to return to IDLE, monitoring each cycle.
    task automatic run_vec(input vec_t v, input int id);
        int          phase;
        logic        r;
        logic        pv;
        logic        pr;
        logic [5:0]  pf;
        logic [5:0]  pt;
        int          emit_cycles;
        logic [63:0] emit_or;
        logic        emit_bad;
        int          done_cnt;
        int          done_cyc;
        logic        finished;
        string       tag;
        tag = $sformatf("v%0d", id);
        phase = 0; pv = 0; pr = 0; pf = 0; pt = 0;
        emit_cycles = 0; emit_or = '0; emit_bad = 0;
        done_cnt = 0; done_cyc = -1; finished = 0;
        exp_q.delete();
        push_expected(v);
        i_board = v.board;
        wtp = v.wtp;
        target_square = v.targets;
        move_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        cyc = 0;
        while (!finished && cyc < 6000) begin
            @(posedge clk); #1;
            cyc++;
            start = (cyc == v.restart_at);
            if (emit_move != 64'd0) begin
                emit_cycles++;
                emit_or |= emit_move;
                if (!$onehot(emit_move)) emit_bad = 1'b1;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (pv && !pr) begin
                check({tag, "_hold_valid"}, 64'(move_valid), 64'd1);
                check({tag, "_hold_from_to"}, {move_from, move_to}, {pf, pt});
            end
            case (v.mode)
                0: r = 1'b1;
                1: begin
                    r = 1'b0;
                    if (move_valid) begin
                        r = (phase == 2);
                        phase = r ? 0 : phase + 1;
                    end
                end
                default: r = 1'($urandom_range(0, 1));
            endcase
            move_ready = r;
            if (move_valid && r) pop_compare({tag, "_move"});
            pv = move_valid; pr = r; pf = move_from; pt = move_to;
            if (!busy && !done) finished = 1'b1;
        end
        move_ready = 1'b0;
        start = 1'b0;
        check({tag, "_finished"}, 64'(finished), 64'd1);
        check({tag, "_count"}, 64'(move_count), 64'(v.exp_count));
        check({tag, "_emit_or"}, emit_or, v.exp_emit_or);
        check({tag, "_emit_cycles"}, 64'(emit_cycles), 64'(v.exp_emit_cycles));
        check({tag, "_emit_onehot"}, 64'(emit_bad), 64'd0);
        check({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
        check({tag, "_moves_left"}, 64'(exp_q.size()), 64'd0);
        if (v.exp_done_cyc >= 0) check({tag, "_done_cycle"}, 64'(done_cyc), 64'(v.exp_done_cyc));
    endtask

    initial begin
        logic [255:0] b1;
        logic [255:0] b3;
        logic [255:0] b5;
        logic         found;
        logic         seen_bad;
        logic [63:0]  t_king;

        // Clock/reset block.
        rst_n = 1'b1; start = 1'b0; abort = 1'b0; wtp = 1'b1;
        i_board = '0; target_square = '0; move_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_emit", emit_move, 64'd0);
        check("rst_valid", 64'(move_valid), 64'd0);
        check("rst_from", 64'(move_from), 64'd0);
        check("rst_to", 64'(move_to), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_count", 64'(move_count), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        t_king = 64'h3828;  // squares 3,5,11,12,13
        b1 = put('0, 4, 4'h9);
        b3 = put(put('0, 52, 4'h6), 20, 4'h8);
        b5 = put(put(put('0, 0, 4'hC), 63, 4'h9), 10, 4'h3);

        vecs[0] = '{'0,  1'b1, 64'd0, 0, -1, 0, 64'd0, 0, 65};
        vecs[1] = '{b1,  1'b1, t_king, 0, -1, 5, 64'h10, 3, 74};
        vecs[2] = '{b1,  1'b1, t_king, 1, -1, 5, 64'h10, 3, 84};
        vecs[3] = '{b3,  1'b1, t_king, 0, -1, 0, 64'd0, 0, 65};
        vecs[4] = '{b3,  1'b0, t_king, 0, -1, 5, 64'h0010_0000_0000_0000, 3, 74};
        vecs[5] = '{b5,  1'b1, 64'h0000_0100_0000_0004, 0, -1, 4, 64'h8000_0000_0000_0001, 6, 77};
        vecs[6] = '{b5,  1'b1, 64'h0000_0100_0000_0004, 2, -1, 4, 64'h8000_0000_0000_0001, 6, -1};
        vecs[7] = '{'0,  1'b1, 64'd0, 0, 10, 0, 64'd0, 0, 65};
        vecs[8] = '{{64{4'h9}}, 1'b1, {64{1'b1}}, 0, -1, 255, {64{1'b1}}, 192, 4417};

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // Abort while the second king move is offered.
        exp_q.delete();
        i_board = b1; wtp = 1'b1; target_square = t_king; move_ready = 1'b1;
        @(posedge clk); #1 start = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(posedge clk); #1 start = 1'b0;
            if (move_valid) found = 1'b1;
        end
        check("abort_first_seen", 64'(found), 64'd1);
        check("abort_first_move", {move_from, move_to}, {6'd4, 6'd3});
        @(posedge clk); #1;
        check("abort_second_valid", 64'(move_valid), 64'd1);
        check("abort_second_move", {move_from, move_to}, {6'd4, 6'd5});
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        move_ready = 1'b0;
        check("abort_valid", 64'(move_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_emit", emit_move, 64'd0);
        check("abort_count", 64'(move_count), 64'd1);
        seen_bad = 1'b0;
        for (int k = 0; k < 80; k++) begin
            if (done || busy || move_valid) seen_bad = 1'b1;
            @(posedge clk); #1;
        end
        check("abort_quiet", 64'(seen_bad), 64'd0);
        check("abort_count_held", 64'(move_count), 64'd1);

        // Start together with abort in IDLE is ignored.
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        seen_bad = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (busy || done) seen_bad = 1'b1;
            @(posedge clk); #1;
        end
        check("start_abort_idle", 64'(seen_bad), 64'd0);

        // Asynchronous reset while a move is held in DRAIN.
        move_ready = 1'b0;
        @(posedge clk); #1 start = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(posedge clk); #1 start = 1'b0;
            if (move_valid) found = 1'b1;
        end
        check("rst_mid_seen", 64'(found), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 64'(move_valid), 64'd0);
        check("rst_mid_from_to", {move_from, move_to}, 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_done", 64'(done), 64'd0);
        check("rst_mid_emit", emit_move, 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        seen_bad = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (busy || done || move_valid) seen_bad = 1'b1;
            @(posedge clk); #1;
        end
        check("rst_mid_quiet", 64'(seen_bad), 64'd0);
        run_vec(vecs[1], 9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/movegen_scan.md
MOVEGEN_SCAN -- requirements
Module: movegen_scan

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2: cycles emit_move is held before target capture (covers slider pass-through chains); legal range 1..15.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  sole clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse, begins a scan
- abort  in  1  synchronous scan cancel
- wtp  in  1  side to play (1 = white)
- i_board  in  256  square nibbles; square idx = (RANK-1)*8+(FILE-1) at bits [4*idx+3:4*idx]
- emit_move  out  64  one-hot source-square strobe, bit idx to square idx
- target_square  in  64  per-square target flags, bit idx from square idx
- move_valid  out  1  move offered
- move_ready  in  1  consumer accepts move
- move_from  out  6  source square idx
- move_to  out  6  target square idx
- busy  out  1  scan in progress
- done  out  1  single-cycle scan-complete pulse
- move_count  out  8  moves accepted this scan, saturating

Function
REQ-003 SHALL compute play_mask[idx] = (nibble[2:0] != 0) && (nibble[3] == wtp), sampled only in the cycle start is accepted, stored in a 64-bit register.
REQ-004 SHALL accept start only in IDLE; start when not IDLE SHALL be ignored.
REQ-005 SHALL implement states IDLE, SCAN, EMIT, CAPTURE, DRAIN, FIN.
REQ-006 IDLE -> SCAN on accepted start; src <= 0, move_count <= 0, busy <= 1 in same edge.
REQ-007 SCAN, one cycle per square: play_mask[src]=1 -> EMIT with settle counter cleared; else src==63 -> FIN; else src <= src+1, stay SCAN.
REQ-008 EMIT SHALL drive emit_move = 1<<src (registered), hold for exactly SETTLE_CYCLES cycles, then -> CAPTURE.
REQ-009 CAPTURE SHALL latch pend = target_square while emit_move still asserted, deassert emit_move on the same edge, go to DRAIN; emit_move SHALL be asserted for SETTLE_CYCLES+1 cycles in total per source square.
REQ-010 DRAIN: pend != 0 SHALL drive move_valid=1, move_from=src, move_to = index of lowest set bit of pend.
REQ-011 move_valid, move_from, move_to SHALL remain stable until the move_valid && move_ready cycle; move_valid SHALL NOT depend combinationally on move_ready.
REQ-012 On handshake: clear that bit of pend; move_count += 1, saturating at 255; next move offered next cycle (at most one move per 1 cycle, back-to-back allowed).
REQ-013 DRAIN with pend == 0 (including empty capture): src==63 -> FIN; else src <= src+1, -> SCAN; move_valid=0 in this cycle.
REQ-014 FIN SHALL pulse done=1 for one cycle, busy <= 0, -> IDLE; move_count held until next accepted start.
REQ-015 abort in any non-IDLE state SHALL, on next edge: -> IDLE, emit_move=0, move_valid=0, busy=0, no done pulse; move_count holds value reached; abort takes priority over handshake in the same cycle (that move not counted).
REQ-016 abort in IDLE SHALL have no effect; start and abort together in IDLE SHALL be ignored (abort wins).
REQ-017 emit_move SHALL be zero in all states other than EMIT/CAPTURE; at most one bit set at any time.
REQ-018 Moves SHALL emerge ordered by ascending move_from, then ascending move_to.

Reset
REQ-019 rst_n low SHALL immediately force: state IDLE, emit_move=0, move_valid=0, move_from=0, move_to=0, busy=0, done=0, move_count=0, src=0, pend=0, play_mask=0, settle counter 0.
REQ-020 Reset mid-scan SHALL discard the scan; no done pulse after release; first start after release SHALL be accepted.

Verification
REQ-021 Empty board, wtp=1, start -> 64 SCAN cycles, done pulse exactly 65 cycles after start, move_count=0, emit_move never set.
REQ-022 White king (0x9) only at idx 4, target_square = bits {3,5,11,12,13}, move_ready=1 -> emit_move=0x10 for 3 cycles (SETTLE_CYCLES=2); moves (4,3),(4,5),(4,11),(4,12),(4,13) on consecutive cycles; move_count=5.
REQ-023 Same as 022 with move_ready toggled 0,0,1 per move -> each move held 3 cycles with stable from/to; identical sequence and count.
REQ-024 Black pawn (0x6) at idx 52, wtp=1 -> idx 52 skipped, no emit_move, done, move_count=0; same with wtp=0 -> emit_move bit 52 asserted.
REQ-025 abort asserted during second move of REQ-022 with move_ready=1 -> next cycle IDLE, move_valid=0, busy=0, no done, move_count=1.
REQ-026 rst_n low mid-DRAIN -> all outputs 0 asynchronously; start after release re-runs scan from idx 0.
